// File: rtl/lcd_pkg.sv
// Shared types and bit positions for the HD44780 bus sequencer.
package lcd_pkg;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_EN_BIT = 10;
  localparam int LCD_RS_BIT = 9;
  localparam int LCD_RW_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    WAIT
  } lcd_state_t;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic [7:0] data;
  } lcd_req_t;

  function automatic lcd_req_t req_from_word(input logic [31:0] word);
    lcd_req_t r;
    r.rs   = word[LCD_RS_BIT];
    r.rw   = word[LCD_RW_BIT];
    r.data = word[7:0];
    return r;
  endfunction

  // Clear display (0x01) and return home (0x02/0x03) need the long execute time.
  function automatic logic is_long_cmd(input lcd_req_t r);
    return !r.rs && ((r.data == 8'h01) || (r.data == 8'h02) || (r.data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_wait_timer.sv
// Loadable down-counter: load N-1 to get an expire pulse on the Nth cycle after the load.
module lcd_wait_timer #(
  parameter int CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  // A load on the expiring cycle keeps the timer running, so phases chain without gaps.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load_i) begin
      r_cnt    <= load_val_i;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == '0) begin
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign expire_o = r_active && (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Turns software EN strobes into timed HD44780 bus cycles with a one-deep pending slot.
// Optional macro LCD_LONG_CMD_EN: clear/home commands get the long execute wait.
module lcd_bus_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC      = 2,
  parameter int PULSE_CYC      = 12,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2500,
  parameter int LONG_WAIT_CYC  = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lcd_reg_i,
  output logic        lcd_on_o,
  output logic        lcd_en_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic [7:0]  lcd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        overrun_o
);

`ifdef LCD_LONG_CMD_EN
  localparam int MAX_WAIT = (LONG_WAIT_CYC > SHORT_WAIT_CYC) ? LONG_WAIT_CYC : SHORT_WAIT_CYC;
`else
  localparam int MAX_WAIT = SHORT_WAIT_CYC;
`endif
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  localparam logic [CNT_W-1:0] SETUP_VAL = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_VAL = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_VAL  = CNT_W'(HOLD_CYC - 1);

  lcd_state_t       r_state;
  lcd_state_t       w_state_next;
  logic             r_en_q;
  logic             r_on;
  lcd_req_t         r_cur;
  lcd_req_t         w_cur_next;
  lcd_req_t         r_pend;
  lcd_req_t         w_pend_next;
  logic             r_pend_vld;
  logic             w_pend_vld_next;
  logic             r_overrun;
  logic             w_overrun_next;
  logic             r_done;
  logic             w_done_next;

  logic             w_req;
  lcd_req_t         w_new_req;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_wait_val;
  logic             w_expire;
  logic             w_last_wait;

  assign w_req       = lcd_reg_i[LCD_EN_BIT] && !r_en_q;
  assign w_new_req   = req_from_word(lcd_reg_i);
  assign w_last_wait = (r_state == WAIT) && w_expire;

`ifdef LCD_LONG_CMD_EN
  assign w_wait_val = is_long_cmd(r_cur) ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(SHORT_WAIT_CYC - 1);
`else
  assign w_wait_val = CNT_W'(SHORT_WAIT_CYC - 1);
`endif

  lcd_wait_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .expire_o   (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_en_q     <= 1'b1;
      r_on       <= 1'b0;
      r_cur      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_overrun  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_en_q     <= lcd_reg_i[LCD_EN_BIT];
      r_on       <= lcd_reg_i[LCD_ON_BIT];
      r_cur      <= w_cur_next;
      r_pend     <= w_pend_next;
      r_pend_vld <= w_pend_vld_next;
      r_overrun  <= w_overrun_next;
      r_done     <= w_done_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cur_next      = r_cur;
    w_pend_next     = r_pend;
    w_pend_vld_next = r_pend_vld;
    w_overrun_next  = r_overrun;
    w_done_next     = 1'b0;
    w_load          = 1'b0;
    w_load_val      = '0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          w_state_next = SETUP;
          w_cur_next   = w_new_req;
          w_load       = 1'b1;
          w_load_val   = SETUP_VAL;
        end
      end
      SETUP: begin
        if (w_expire) begin
          w_state_next = PULSE;
          w_load       = 1'b1;
          w_load_val   = PULSE_VAL;
        end
      end
      PULSE: begin
        if (w_expire) begin
          w_state_next = HOLD;
          w_load       = 1'b1;
          w_load_val   = HOLD_VAL;
        end
      end
      HOLD: begin
        if (w_expire) begin
          w_state_next = WAIT;
          w_load       = 1'b1;
          w_load_val   = w_wait_val;
        end
      end
      WAIT: begin
        if (w_expire) begin
          w_done_next = 1'b1;
          // The pending entry goes first; a request arriving now takes its place.
          if (r_pend_vld) begin
            w_state_next    = SETUP;
            w_cur_next      = r_pend;
            w_load          = 1'b1;
            w_load_val      = SETUP_VAL;
            w_pend_vld_next = w_req;
            if (w_req) begin
              w_pend_next = w_new_req;
            end
          end else if (w_req) begin
            w_state_next = SETUP;
            w_cur_next   = w_new_req;
            w_load       = 1'b1;
            w_load_val   = SETUP_VAL;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_req && (r_state != IDLE) && !w_last_wait) begin
      if (r_pend_vld) begin
        w_overrun_next = 1'b1;
      end else begin
        w_pend_next     = w_new_req;
        w_pend_vld_next = 1'b1;
      end
    end
  end

  assign lcd_on_o   = r_on;
  assign lcd_en_o   = (r_state == PULSE);
  assign lcd_rs_o   = r_cur.rs;
  assign lcd_rw_o   = r_cur.rw;
  assign lcd_data_o = r_cur.data;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;
  assign overrun_o  = r_overrun;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer with a transaction scoreboard checked on each done pulse.
module tb_lcd_bus_sequencer;

  localparam int SETUP_CYC  = 2;
  localparam int PULSE_CYC  = 12;
  localparam int HOLD_CYC   = 2;
  localparam int SHORT_WAIT = 2500;
`ifdef LCD_LONG_CMD_EN
  localparam int CLEAR_WAIT = 82000;
`else
  localparam int CLEAR_WAIT = 2500;
`endif
  localparam int TXN_BUSY = SETUP_CYC + PULSE_CYC + HOLD_CYC + SHORT_WAIT;

  logic        clk;
  logic        rst;
  logic [31:0] lcd_reg;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  logic        busy;
  logic        done;
  logic        overrun;

  lcd_bus_sequencer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .lcd_reg_i  (lcd_reg),
    .lcd_on_o   (lcd_on),
    .lcd_en_o   (lcd_en),
    .lcd_rs_o   (lcd_rs),
    .lcd_rw_o   (lcd_rw),
    .lcd_data_o (lcd_data),
    .busy_o     (busy),
    .done_o     (done),
    .overrun_o  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] word;
    int         wait_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   s_cyc = 0;
  int   en_rise_cyc = 0;
  int   fall_cyc = 0;
  int   pulse_len = 0;
  int   busy_run = 0;
  int   last_run = 0;
  logic en_prev = 1'b0;
  logic [9:0] mon_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: capture bus fields at E rise, pulse width, and E-fall-to-done distance.
  always @(negedge clk) begin
    if (rst) begin
      en_prev  = 1'b0;
      busy_run = 0;
    end else begin
      if (lcd_en && !en_prev) begin
        en_rise_cyc = cyc;
        mon_word    = {lcd_rs, lcd_rw, lcd_data};
        pulse_len   = 0;
      end
      if (lcd_en) pulse_len++;
      if (!lcd_en && en_prev) fall_cyc = cyc;
      en_prev = lcd_en;
      if (busy) busy_run++;
      else if (busy_run > 0) begin
        last_run = busy_run;
        busy_run = 0;
      end
      if (done) begin
        chk("done_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("txn_bus_word", 32'(mon_word), 32'(e.word));
          chk("txn_en_width", pulse_len, PULSE_CYC);
          chk("txn_fall_to_done", cyc - fall_cyc, HOLD_CYC + e.wait_cyc);
          $display("txn word=0x%03h en_width=%0d fall_to_done=%0d", mon_word, pulse_len, cyc - fall_cyc);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] w, input int wait_cyc);
    exp_t e;
    e.word     = {w[9], w[8], w[7:0]};
    e.wait_cyc = wait_cyc;
    sb.push_back(e);
  endtask

  task automatic strobe(input logic [31:0] w);
    @(negedge clk);
    lcd_reg = w | 32'h0000_0400;
    s_cyc   = cyc;
    @(negedge clk);
    lcd_reg[10] = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    for (i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (i == bound) chk("idle_timeout", 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst     = 1'b1;
    lcd_reg = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(lcd_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_on", 32'(lcd_on), 0);
    chk("rst_data", 32'({lcd_rs, lcd_rw, lcd_data}), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single data write
    lcd_reg = 32'h8000_0241;
    @(negedge clk);
    chk("t1_on", 32'(lcd_on), 1);
    push_exp(32'h241, SHORT_WAIT);
    strobe(32'h8000_0241);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_rs", 32'(lcd_rs), 1);
    chk("t1_data", 32'(lcd_data), 32'h41);
    wait_idle(3000);
    chk("t1_en_offset", en_rise_cyc - s_cyc, SETUP_CYC + 1);
    chk("t1_busy_len", last_run, TXN_BUSY);
    chk("t1_data_held", 32'(lcd_data), 32'h41);

    // 2: clear display
    push_exp(32'h001, CLEAR_WAIT);
    strobe(32'h8000_0001);
    wait_idle(CLEAR_WAIT + 100);
    chk("t2_busy_len", last_run, SETUP_CYC + PULSE_CYC + HOLD_CYC + CLEAR_WAIT);

    // 3: three strobes in one busy window
    push_exp(32'h230, SHORT_WAIT);
    push_exp(32'h131, SHORT_WAIT);
    strobe(32'h8000_0230);
    repeat (5) @(negedge clk);
    strobe(32'h8000_0131);
    chk("t3_no_overrun_yet", 32'(overrun), 0);
    strobe(32'h8000_0132);
    @(negedge clk);
    chk("t3_overrun", 32'(overrun), 1);
    wait_idle(6000);
    chk("t3_busy_contig", last_run, 2 * TXN_BUSY);
    chk("t3_last_data", 32'(lcd_data), 32'h31);
    chk("t3_overrun_sticky", 32'(overrun), 1);

    // 4: reset during the E pulse
    strobe(32'h8000_0242);
    for (int i = 0; i < 10 && !lcd_en; i++) @(negedge clk);
    chk("t4_in_pulse", 32'(lcd_en), 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_en", 32'(lcd_en), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_overrun", 32'(overrun), 0);
    rst     = 1'b0;
    lcd_reg = 32'h8000_0000;
    @(negedge clk);
    push_exp(32'h241, SHORT_WAIT);
    strobe(32'h8000_0241);
    wait_idle(3000);
    chk("t4_en_offset", en_rise_cyc - s_cyc, SETUP_CYC + 1);
    chk("t4_busy_len", last_run, TXN_BUSY);

    // 5: EN held high across reset release
    @(negedge clk);
    lcd_reg = 32'h0000_0641;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_no_txn_busy", 32'(busy), 0);
    chk("t5_no_txn_data", 32'(lcd_data), 0);
    lcd_reg = 32'h0000_0241;
    @(negedge clk);
    push_exp(32'h241, SHORT_WAIT);
    strobe(32'h0000_0241);
    wait_idle(3000);
    chk("t5_en_offset", en_rise_cyc - s_cyc, SETUP_CYC + 1);

    // 6: toggle ON bit while busy
    push_exp(32'h155, SHORT_WAIT);
    strobe(32'h0000_0155);
    for (int j = 0; j < 8; j++) begin
      logic b;
      b = (j % 2 == 0);
      lcd_reg[31] = b;
      @(negedge clk);
      chk("t6_on_follow", 32'(lcd_on), 32'(b));
    end
    wait_idle(3000);
    chk("t6_en_offset", en_rise_cyc - s_cyc, SETUP_CYC + 1);
    chk("t6_busy_len", last_run, TXN_BUSY);
    chk("t6_data", 32'(lcd_data), 32'h55);

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
